button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Consumes the raw, bouncing `btn` level produced by `buttonEmulator` (or a board pushbutton) and delivers a clean debounced level.
- Also produces single-cycle press and release strobes, a long-press strobe, and a saturating press counter.
- Sits directly downstream of the button source and upstream of any user-facing control logic.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a level change; legal range is 1 or more.
- LONG_PRESS_CYCLES, 200: debounced-high cycles after `press` before `long_press` fires; legal range is 1 or more.
- COUNT_WIDTH, 8: width of `press_count`.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- btn  in  1  raw, asynchronous, bouncing button level (1 = pressed).
- clr_count  in  1  synchronous clear of `press_count`.
- btn_db  out  1  debounced button level.
- press  out  1  one-cycle strobe when a press is accepted.
- release  out  1  one-cycle strobe when a release is accepted.
- long_press  out  1  one-cycle strobe, at most once per accepted press.
- press_count  out  COUNT_WIDTH  number of accepted presses, saturating.

Behaviour:
- Reset:
  - Applies when `rst_n` = 0 at a clk edge.
  - State goes to RELEASED; synchronizer flops, stability counter and hold counter clear to 0.
  - All outputs go to 0, including `press_count`.
  - Reset overrides all other inputs.
- Synchronizer:
  - Two flops: `btn` -> s1 -> s2 (`btn_s`).
  - The FSM only ever looks at `btn_s`.
- Stability counter (`cnt`):
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - Counts consecutive `btn_s` samples at the candidate level.
  - Clears on any FSM state change.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if `btn_s` = 1, go to PRESS_WAIT with `cnt` = 1.
  - PRESS_WAIT, `btn_s` = 0: the bounce is rejected; return to RELEASED with no output activity.
  - PRESS_WAIT, `btn_s` = 1 and this is the DEBOUNCE_CYCLES-th consecutive high sample: go to PRESSED and register `btn_db` = 1 and `press` = 1.
  - PRESS_WAIT, `btn_s` = 1 otherwise: increment `cnt`.
  - PRESSED: `hold` increments each cycle, saturating at LONG_PRESS_CYCLES. If `btn_s` = 0, go to RELEASE_WAIT with `cnt` = 1.
  - RELEASE_WAIT, `btn_s` = 1: return to PRESSED. `hold` is NOT cleared and `press` does not re-fire.
  - RELEASE_WAIT, `btn_s` = 0 and this is the DEBOUNCE_CYCLES-th consecutive low sample: go to RELEASED, register `btn_db` = 0 and `release` = 1, clear `hold`.
  - RELEASE_WAIT, `btn_s` = 0 otherwise: increment `cnt`.
- DEBOUNCE_CYCLES = 1: PRESS_WAIT is entered and left on the same accepting sample; RELEASED goes straight to PRESSED with `press` = 1. RELEASE_WAIT behaves the same way.
- Latency:
  - Let edge k be the first edge that samples `btn` = 1, with `btn` then held steady.
  - `press` and `btn_db` are registered high at edge k+1+DEBOUNCE_CYCLES.
  - Release is symmetric.
- Strobes:
  - `press`, `release` and `long_press` are high for exactly one cycle.
  - `press` and `release` can never be high in the same cycle.
- Long press:
  - `long_press` is registered at the edge where `hold` reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES edges after the `press` edge.
  - It fires at most once per accepted press.
  - No `long_press` if release is accepted first.
- press_count:
  - Increments on every `press` strobe; saturates at 2^COUNT_WIDTH-1 with no wrap.
  - `clr_count` alone sets it to 0.
  - `clr_count` in the same cycle as a `press` increment sets it to 1.
- Reset mid-operation:
  - Everything returns to the reset state.
  - If the button is still held, the press is re-qualified from RELEASED, so a new `press` strobe follows DEBOUNCE_CYCLES+2 edges after reset release. This is required behaviour.
- All outputs are registered; no combinational path from `btn` to any output.

Decomposition:
- Package `button_pkg`:
  - State encoding typedef `btn_state_t` with values RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - Shared default constants for DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
- Sub-module `sync_2ff`: two-flop single-bit synchronizer, reset to 0, reusable for other asynchronous inputs.
- Top level: FSM, `cnt`, `hold` and `press_count`.

Test Plan:
1. Reset/idle: hold `rst_n` = 0 for 3 cycles, `btn` = 0 -> all outputs 0; `press_count` = 0 for 50 cycles after reset release.
2. Clean press and release (DEBOUNCE_CYCLES = 16):
   - `btn` rises with first sampling edge k = 10 -> `press` high only after edge 27; `btn_db` = 1 from edge 27; `press_count` = 1.
   - `btn` falls sampled at edge 100 -> `release` high only after edge 117; `btn_db` = 0.
3. Bounce rejection:
   - Toggle `btn` with high pulses of 5 cycles, 8 times -> no strobes and `btn_db` stays 0.
   - Then hold `btn` = 1 -> exactly one `press`.
   - Release with 10-cycle glitches -> exactly one `release`.
4. Long press (LONG_PRESS_CYCLES = 200):
   - Hold for 300 cycles -> `long_press` strobes once, 200 edges after the `press` edge.
   - A 150-cycle hold gives no `long_press`.
   - A 12-cycle low glitch mid-hold neither resets `hold` nor re-fires `press`.
5. Counter:
   - COUNT_WIDTH = 3 with 10 presses -> `press_count` saturates at 7.
   - Assert `clr_count` together with a `press` strobe -> `press_count` = 1.
   - `clr_count` alone -> `press_count` = 0.
6. Reset mid-press: hold `btn` = 1, accept the press, pulse `rst_n` low for 1 cycle -> outputs clear, and `press` re-fires 18 edges after reset release.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and default timing constants for the button debouncer
package button_pkg;
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 200;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer for asynchronous inputs, cleared on reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  // shift the raw level through two flops to settle metastability
  always_ff @(posedge clk)
    if (!rst_n) {s2_q, s1_q} <= 2'b00;
    else {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounced level, press/release/long-press strobes and saturating press count
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_i,
  input  logic                   clr_count_i,
  output logic                   btn_db_o,
  output logic                   press_o,
  output logic                   release_o,
  output logic                   long_press_o,
  output logic [COUNT_WIDTH-1:0] press_count_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);
  localparam bit ONE_SHOT = DEBOUNCE_CYCLES == 1;

  logic btn_s;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic db_q, db_d, press_q, press_d, rel_q, rel_d, lp_q, lp_d;
  logic [COUNT_WIDTH-1:0] pc_q, pc_d;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (btn_i),
    .q_o  (btn_s)
  );

  // next state: qualify each candidate level for DEBOUNCE_CYCLES samples, time the hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lp_d    = 1'b0;
    case (state_q)
      RELEASED:
        if (btn_s) begin
          if (ONE_SHOT) begin
            state_d = PRESSED;
            db_d    = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      PRESS_WAIT:
        if (!btn_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          db_d    = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      PRESSED: begin
        if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
          lp_d   = hold_q == HOLD_PRE;
        end
        if (!btn_s) begin
          if (ONE_SHOT) begin
            state_d = RELEASED;
            db_d    = 1'b0;
            rel_d   = 1'b1;
            hold_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      RELEASE_WAIT:
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          db_d    = 1'b0;
          rel_d   = 1'b1;
          hold_d  = '0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // press counter: clear wins but still counts a simultaneous press, saturates at all-ones
  always_comb
    pc_d = clr_count_i ? COUNT_WIDTH'(press_d) :
           (press_d && pc_q != '1) ? pc_q + COUNT_WIDTH'(1) : pc_q;

  // state, counters and registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      hold_q  <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lp_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lp_q    <= lp_d;
      pc_q    <= pc_d;
    end

  assign btn_db_o      = db_q;
  assign press_o       = press_q;
  assign release_o     = rel_q;
  assign long_press_o  = lp_q;
  assign press_count_o = pc_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench with a run-length reference model for two configurations
module tb_button_debouncer;
  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, clr = 1'b0;
  logic a_db, a_p, a_r, a_l;
  logic [2:0] a_c;
  logic b_db, b_p, b_r, b_l;
  logic [1:0] b_c;
  int checks = 0, errors = 0;
  int na_p = 0, na_r = 0, na_l = 0;
  int s_p, s_r, s_l;

  typedef struct {
    bit s1, s2, db, p, r, l;
    int run, hold, cnt;
  } mdl_t;
  mdl_t ma, mb;
  int qa[$], qb[$];

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(16), .LONG_PRESS_CYCLES(200), .COUNT_WIDTH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .clr_count_i(clr),
    .btn_db_o(a_db), .press_o(a_p), .release_o(a_r), .long_press_o(a_l), .press_count_o(a_c)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(1), .LONG_PRESS_CYCLES(3), .COUNT_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .clr_count_i(clr),
    .btn_db_o(b_db), .press_o(b_p), .release_o(b_r), .long_press_o(b_l), .press_count_o(b_c)
  );

  // run: consecutive synchronized samples disagreeing with the debounced level
  function automatic mdl_t step(mdl_t m, bit rn, bit b, bit c, int d, int l, int cmax);
    mdl_t n = m;
    n.p = 0; n.r = 0; n.l = 0;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    n.s1 = b;
    n.s2 = m.s1;
    if (m.db && m.run == 0 && m.hold < l) begin
      n.hold = m.hold + 1;
      n.l = (n.hold == l);
    end
    if (m.s2 != m.db) begin
      n.run = m.run + 1;
      if (n.run == d) begin
        n.db = m.s2; n.run = 0; n.p = m.s2; n.r = !m.s2;
        if (!m.s2) n.hold = 0;
      end
    end else n.run = 0;
    if (c) n.cnt = int'(n.p);
    else if (n.p && m.cnt < cmax) n.cnt = m.cnt + 1;
    return n;
  endfunction

  function automatic int pack(bit db, bit p, bit r, bit l, int c);
    return (int'({db, p, r, l}) << 16) | c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_btn(input bit v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_p = na_p; s_r = na_r; s_l = na_l;
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst_n, btn, clr, 16, 200, 7);
    mb = step(mb, rst_n, btn, clr, 1, 3, 3);
    qa.push_back(pack(ma.db, ma.p, ma.r, ma.l, ma.cnt));
    qb.push_back(pack(mb.db, mb.p, mb.r, mb.l, mb.cnt));
  end

  always @(negedge clk) begin
    if (qa.size() > 0) chk("sb_a", pack(a_db, a_p, a_r, a_l, int'(a_c)), qa.pop_front());
    if (qb.size() > 0) chk("sb_b", pack(b_db, b_p, b_r, b_l, int'(b_c)), qb.pop_front());
    if (a_p && a_r) chk("a_press_and_release", 1, 0);
    na_p += int'(a_p); na_r += int'(a_r); na_l += int'(a_l);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", pack(a_db, a_p, a_r, a_l, int'(a_c)), 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_outputs", pack(a_db, a_p, a_r, a_l, int'(a_c)), 0);
    btn = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 chk("b_press_k1", int'(b_p), 0);
    @(posedge clk); #1 chk("b_press_k2", int'(b_p), 1);
    repeat (14) @(posedge clk);
    #1 chk("a_press_k16", int'({a_p, a_db}), 0);
    @(posedge clk); #1 chk("a_press_k17", int'({a_p, a_db}), 3);
    chk("a_count_first", int'(a_c), 1);
    repeat (199) @(posedge clk);
    #1 chk("long_press_early", int'(a_l), 0);
    @(posedge clk); #1 chk("long_press_200", int'(a_l), 1);
    @(posedge clk); #1 chk("long_press_one_cycle", int'(a_l), 0);
    @(negedge clk);
    repeat (80) @(negedge clk);
    btn = 1'b0;
    @(posedge clk);
    repeat (16) @(posedge clk);
    #1 chk("release_k16", int'({a_r, a_db}), 1);
    @(posedge clk); #1 chk("release_k17", int'({a_r, a_db}), 2);
    @(negedge clk);
    set_btn(0, 30);
    snap();
    for (int i = 0; i < 8; i++) begin
      set_btn(1, 5);
      set_btn(0, $urandom_range(2, 8));
    end
    chk("bounce_no_press", na_p - s_p, 0);
    set_btn(1, 40);
    chk("bounce_one_press", na_p - s_p, 1);
    for (int i = 0; i < 4; i++) begin
      set_btn(0, 10);
      set_btn(1, $urandom_range(1, 3));
    end
    chk("glitch_no_release", na_r - s_r, 0);
    set_btn(0, 40);
    chk("glitch_one_release", na_r - s_r, 1);
    snap();
    set_btn(1, 150);
    set_btn(0, 40);
    chk("short_hold_no_long", na_l - s_l, 0);
    snap();
    set_btn(1, 100);
    set_btn(0, 12);
    set_btn(1, 250);
    set_btn(0, 40);
    chk("mid_glitch_press", na_p - s_p, 1);
    chk("mid_glitch_long", na_l - s_l, 1);
    for (int i = 0; i < 10; i++) begin
      set_btn(1, 20);
      set_btn(0, 20);
    end
    chk("count_saturate", int'(a_c), 7);
    btn = 1'b1;
    repeat (17) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1 chk("clr_with_press", int'({a_p, a_c}), 9);
    @(negedge clk);
    clr = 1'b0;
    set_btn(1, 10);
    set_btn(0, 40);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_alone", int'(a_c), 0);
    repeat (60) begin
      clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 30) != 0);
      set_btn(1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    clr = 1'b0;
    rst_n = 1'b1;
    set_btn(0, 40);
    set_btn(1, 40);
    chk("held_before_reset", int'(a_db), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_clear", pack(a_db, a_p, a_r, a_l, int'(a_c)), 0);
    rst_n = 1'b1;
    repeat (17) @(posedge clk);
    #1 chk("repress_17", int'(a_p), 0);
    @(posedge clk); #1 chk("repress_18", int'(a_p), 1);
    @(negedge clk);
    set_btn(0, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
